dds_param_ctrl: RTL
===================

DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

Interface
REQ-001 Parameter BASE_WORD, default 32'd85899, frequency control word at step index 0 (1 kHz at 50 MHz clk).
REQ-002 Parameter MAX_IDX, default 3'd7, highest frequency step index.
REQ-003 Port clk, input, 1, the single system clock; all logic on rising edge.
REQ-004 Port rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-005 Port key_freq_add_flag, input, 1, single-cycle pulse from the key debouncer: step frequency up.
REQ-006 Port key_freq_sub_flag, input, 1, single-cycle pulse: step frequency down.
REQ-007 Port key_a_flag, input, 1, single-cycle pulse: step amplitude attenuation.
REQ-008 Port wave_flag, input, 1, single-cycle pulse: step waveform.
REQ-009 Port freq_word, output, 32, active frequency control word.
REQ-010 Port wave_sel, output, 2, active waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-011 Port amp_sel, output, 2, active attenuation: 0 full, 1 half, 2 quarter, 3 eighth (right-shift count for the downstream scaler).
REQ-012 Port phase_acc, output, 32, phase accumulator value.
REQ-013 Port rom_addr, output, 10, {wave_sel, phase_acc[31:24]}, registered with phase_acc.
REQ-014 Port param_upd, output, 1, one-cycle pulse on the cycle active parameters change.

Function
REQ-015 Pending registers shall hold freq_idx (3 b), wave_pend (2 b) and amp_pend (2 b); each is updated one cycle after its input flag.
REQ-016 key_freq_add_flag alone shall increment freq_idx, saturating at MAX_IDX.
REQ-017 key_freq_sub_flag alone shall decrement freq_idx, saturating at 0.
REQ-018 key_freq_add_flag and key_freq_sub_flag in the same cycle shall leave freq_idx unchanged.
REQ-019 wave_flag shall increment wave_pend modulo 4 (3 wraps to 0).
REQ-020 key_a_flag shall increment amp_pend modulo 4 (3 wraps to 0).
REQ-021 Flags arriving in the same cycle on different controls shall all take effect independently.
REQ-022 Pending frequency word shall be BASE_WORD << freq_idx, truncated to 32 b.
REQ-023 phase_acc shall add freq_word every cycle, modulo 2^32.
REQ-024 wrap = carry out of that 33-bit sum.
REQ-025 A dirty bit shall set whenever any pending register changes value; a flag producing no change (saturation, add+sub) shall not set it.
REQ-026 On a cycle with wrap=1 and dirty=1, the next edge shall load freq_word, wave_sel and amp_sel from pending, clear dirty and pulse param_upd for one cycle.
REQ-027 A flag landing on that same load edge shall update pending and re-set dirty; the new value is applied at the following wrap.
REQ-028 Active outputs shall change only per REQ-026; no parameter change mid-period.
REQ-029 If freq_word is 0, phase_acc shall hold and never wrap, so pending changes are never applied.

Reset
REQ-030 While rst=1 at a clock edge: freq_idx, wave_pend, amp_pend = 0; freq_word = BASE_WORD; wave_sel = 0; amp_sel = 0; phase_acc = 0; rom_addr = 0; dirty = 0; param_upd = 0.
REQ-031 Reset asserted mid-operation shall discard pending changes and dirty state at that edge.
REQ-032 Normal operation resumes on the first edge with rst=0.

Verification (BASE_WORD = 32'h0100_0000, so idx 0 wraps every 256 cycles)
REQ-033 Reset release, no flags -> freq_word = 32'h0100_0000, rom_addr advances by 1 per cycle, param_upd never asserts.
REQ-034 One key_freq_add_flag pulse -> freq_idx = 1 next cycle; freq_word stays 32'h0100_0000 until the next wrap; then freq_word = 32'h0200_0000 with a single param_upd pulse.
REQ-035 Ten add pulses, then ten sub pulses -> freq_idx saturates at 7 (freq_word 32'h8000_0000 after wrap), then at 0; an extra sub pulse at 0 leaves dirty clear.
REQ-036 Simultaneous add+sub pulse -> no change and no param_upd; simultaneous wave_flag+key_a_flag -> wave_sel = 1 and amp_sel = 1 on the same update.
REQ-037 Five wave_flag pulses -> wave_sel = 1 after wrap; rom_addr[9:8] = 1.
REQ-038 Pending change made, rst pulsed for one cycle before wrap -> all outputs at reset values; no param_upd follows.

Source files
------------

// File: rtl/dds_param_ctrl.sv
// dds_param_ctrl: key-driven DDS parameter control with wrap-synchronised updates.
// Key flags adjust pending frequency/waveform/attenuation settings. A dirty bit
// tracks unapplied changes. Pending values become active only on the edge that
// follows a phase-accumulator wrap, so a waveform period is never cut mid-way.
module dds_param_ctrl #(
    parameter logic [31:0] BASE_WORD = 32'd85899,
    parameter logic [2:0]  MAX_IDX   = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_freq_add_flag,
    input  logic        key_freq_sub_flag,
    input  logic        key_a_flag,
    input  logic        wave_flag,
    output logic [31:0] freq_word,
    output logic [1:0]  wave_sel,
    output logic [1:0]  amp_sel,
    output logic [31:0] phase_acc,
    output logic [9:0]  rom_addr,
    output logic        param_upd
);

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned ADDR_W = SEL_W + 8;

    // Pending (requested) settings
    logic [IDX_W-1:0]  r_freq_idx;
    logic [SEL_W-1:0]  r_wave_pend;
    logic [SEL_W-1:0]  r_amp_pend;
    logic              r_dirty;

    // Active settings and accumulator
    logic [ACC_W-1:0]  r_freq_word;
    logic [SEL_W-1:0]  r_wave_sel;
    logic [SEL_W-1:0]  r_amp_sel;
    logic [ACC_W-1:0]  r_phase_acc;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_param_upd;

    logic [IDX_W-1:0]  w_freq_idx_nxt;
    logic              w_freq_chg;
    logic              w_pend_chg;
    logic [ACC_W:0]    w_sum;
    logic              w_wrap;
    logic              w_load;
    logic [ACC_W-1:0]  w_pend_word;
    logic [SEL_W-1:0]  w_wave_sel_nxt;

    // Frequency index step: saturating, and add+sub together cancel out
    always_comb begin
        w_freq_idx_nxt = r_freq_idx;
        if (key_freq_add_flag && !key_freq_sub_flag) begin
            if (r_freq_idx < MAX_IDX) begin
                w_freq_idx_nxt = r_freq_idx + IDX_W'(1);
            end
        end else if (key_freq_sub_flag && !key_freq_add_flag) begin
            if (r_freq_idx != IDX_W'(0)) begin
                w_freq_idx_nxt = r_freq_idx - IDX_W'(1);
            end
        end
    end

    // Change detection, wrap detection and load decision
    always_comb begin
        w_freq_chg     = (w_freq_idx_nxt != r_freq_idx);
        // Modulo-4 increments always change the value, so a flag implies a change
        w_pend_chg     = w_freq_chg | key_a_flag | wave_flag;
        w_sum          = {1'b0, r_phase_acc} + {1'b0, r_freq_word};
        w_wrap         = w_sum[ACC_W];
        w_load         = w_wrap & r_dirty;
        w_pend_word    = BASE_WORD << r_freq_idx;
        w_wave_sel_nxt = w_load ? r_wave_pend : r_wave_sel;
    end

    // Pending registers and dirty tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq_idx  <= '0;
            r_wave_pend <= '0;
            r_amp_pend  <= '0;
            r_dirty     <= 1'b0;
        end else begin
            r_freq_idx <= w_freq_idx_nxt;
            if (wave_flag) begin
                r_wave_pend <= r_wave_pend + SEL_W'(1);
            end
            if (key_a_flag) begin
                r_amp_pend <= r_amp_pend + SEL_W'(1);
            end
            // A change landing on the load edge keeps dirty set for the next wrap
            if (w_pend_chg) begin
                r_dirty <= 1'b1;
            end else if (w_load) begin
                r_dirty <= 1'b0;
            end
        end
    end

    // Active parameters, phase accumulator and ROM address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq_word <= BASE_WORD;
            r_wave_sel  <= '0;
            r_amp_sel   <= '0;
            r_phase_acc <= '0;
            r_rom_addr  <= '0;
            r_param_upd <= 1'b0;
        end else begin
            r_phase_acc <= w_sum[ACC_W-1:0];
            r_rom_addr  <= {w_wave_sel_nxt, w_sum[ACC_W-1:ACC_W-8]};
            r_param_upd <= w_load;
            if (w_load) begin
                r_freq_word <= w_pend_word;
                r_wave_sel  <= r_wave_pend;
                r_amp_sel   <= r_amp_pend;
            end
        end
    end

    assign freq_word = r_freq_word;
    assign wave_sel  = r_wave_sel;
    assign amp_sel   = r_amp_sel;
    assign phase_acc = r_phase_acc;
    assign rom_addr  = r_rom_addr;
    assign param_upd = r_param_upd;

endmodule
